// File: rtl/burst_arbiter.sv
// Arbitrates the icache and dcache line requests onto one burst memory port.
// Lines move as BEATS bursts of BEAT_W bits; one transaction is in flight at a time.
module burst_arbiter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               dfp_addr,
    input  logic                      dfp_read,
    output logic [BEATS*BEAT_W-1:0]   dfp_rdata,
    output logic                      dfp_resp,
    input  logic [31:0]               dfp_daddr,
    input  logic                      dfp_dread,
    input  logic                      dfp_dwrite,
    input  logic [BEATS*BEAT_W-1:0]   dfp_dwdata,
    output logic [BEATS*BEAT_W-1:0]   dfp_drdata,
    output logic                      dfp_dresp,
    output logic [31:0]               bmem_addr,
    output logic                      bmem_read,
    output logic                      bmem_write,
    output logic [BEAT_W-1:0]         bmem_wdata,
    input  logic                      bmem_ready,
    input  logic [BEAT_W-1:0]         bmem_rdata,
    input  logic                      bmem_rvalid,
    output logic                      grant_d
);

    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);

    typedef enum logic [2:0] {S_IDLE, S_RD_CMD, S_RD_DATA, S_WR, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic                gnt_d_q, gnt_d_d;
    logic                last_d_q, last_d_d;

    logic req_i, req_d, pick_d, last_beat;

    assign req_i     = dfp_read;
    assign req_d     = dfp_dread | dfp_dwrite;
    // On a tie the cache that did not win last time gets the port.
    assign pick_d    = req_d & (~req_i | ~last_d_q);
    assign last_beat = (beat_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            line_q   <= '0;
            beat_q   <= '0;
            gnt_d_q  <= 1'b0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            gnt_d_q  <= gnt_d_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        line_d   = line_q;
        beat_d   = beat_q;
        gnt_d_d  = gnt_d_q;
        last_d_d = last_d_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i | req_d) begin
                    gnt_d_d = pick_d;
                    beat_d  = '0;
                    addr_d  = pick_d ? dfp_daddr : dfp_addr;
                    if (pick_d && dfp_dwrite) begin
                        line_d  = dfp_dwdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD_CMD;
                    end
                end
            end
            S_RD_CMD: begin
                if (bmem_ready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (bmem_rvalid) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_q == CNT_W'(b)) line_d[b*BEAT_W +: BEAT_W] = bmem_rdata;
                    end
                    beat_d = beat_q + CNT_W'(1);
                    if (last_beat) state_d = S_RESP;
                end
            end
            S_WR: begin
                if (bmem_ready) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (last_beat) state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_d_d = gnt_d_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bmem_read  = (state_q == S_RD_CMD);
        bmem_write = (state_q == S_WR);
        bmem_wdata = '0;
        if (state_q == S_WR) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_q == CNT_W'(b)) bmem_wdata = line_q[b*BEAT_W +: BEAT_W];
            end
        end
        dfp_resp   = (state_q == S_RESP) & ~gnt_d_q;
        dfp_dresp  = (state_q == S_RESP) &  gnt_d_q;
        dfp_rdata  = dfp_resp  ? line_q : '0;
        dfp_drdata = dfp_dresp ? line_q : '0;
    end

    assign bmem_addr = addr_q;
    assign grant_d   = gnt_d_q;

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed bench for burst_arbiter: a small burst-memory model plus a response scoreboard.
module tb_burst_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr, dfp_daddr, bmem_addr;
    logic         dfp_read, dfp_resp, dfp_dread, dfp_dwrite, dfp_dresp;
    logic [255:0] dfp_rdata, dfp_dwdata, dfp_drdata;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid, grant_d;
    logic [63:0]  bmem_wdata, bmem_rdata;

    burst_arbiter #(.BEATS(4), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .dfp_daddr(dfp_daddr), .dfp_dread(dfp_dread), .dfp_dwrite(dfp_dwrite),
        .dfp_dwdata(dfp_dwdata), .dfp_drdata(dfp_drdata), .dfp_dresp(dfp_dresp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_d;
        logic [255:0] data;
        bit           chk_data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [63:0] rd_q[$];
    logic [63:0] wr_log[$];
    bit ready_toggle = 1'b0;
    bit stray = 1'b0;
    bit acc_rd;
    int rd_cmds = 0, beats_given = 0, beats_left = 0;
    int last_wr_cyc = 0, last_resp_cyc = 0;
    bit prev_resp = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    // Memory model: accepts commands/beats sampled mid-cycle, streams read beats after the command.
    initial begin
        bmem_ready = 1'b1; bmem_rvalid = 1'b0; bmem_rdata = '0;
        forever begin
            @(negedge clk);
            acc_rd = bmem_read && bmem_ready && !rst;
            if (bmem_write && bmem_ready && !rst) begin
                wr_log.push_back(bmem_wdata);
                last_wr_cyc = cyc;
            end
            @(posedge clk); #1;
            if (acc_rd) begin rd_cmds++; beats_left = 4; end
            bmem_rvalid = 1'b0; bmem_rdata = '0;
            if (beats_left > 0 && rd_q.size() > 0) begin
                bmem_rvalid = 1'b1; bmem_rdata = rd_q.pop_front();
                beats_left--; beats_given++;
            end else if (stray) begin
                bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; stray = 1'b0;
            end
            bmem_ready = ready_toggle ? ~bmem_ready : 1'b1;
        end
    end

    // Response scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (dfp_resp || dfp_dresp) begin
                chk("resp_exclusive", {255'd0, dfp_resp & dfp_dresp}, 256'd0);
                chk("resp_single_pulse", {255'd0, prev_resp}, 256'd0);
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL resp_expected: observed resp with empty queue, required none");
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("resp_owner", {255'd0, dfp_dresp}, {255'd0, mon_e.is_d});
                    chk("grant_d_at_resp", {255'd0, grant_d}, {255'd0, mon_e.is_d});
                    if (mon_e.chk_data)
                        chk("resp_data", mon_e.is_d ? dfp_drdata : dfp_rdata, mon_e.data);
                end
                last_resp_cyc = cyc;
            end
            prev_resp = dfp_resp | dfp_dresp;
        end
    end

    task automatic load_beats(input logic [63:0] b0, b1, b2, b3, output logic [255:0] line);
        rd_q.push_back(b0); rd_q.push_back(b1); rd_q.push_back(b2); rd_q.push_back(b3);
        line = {b3, b2, b1, b0};
    endtask

    task automatic wait_resp(input bit d, input string tag);
        int n = 0;
        while (!(d ? dfp_dresp : dfp_resp) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, {255'd0, n < 200}, 256'd1);
        @(posedge clk); #1;
        if (d) begin dfp_dread = 1'b0; dfp_dwrite = 1'b0; end
        else dfp_read = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bmem_read"}, {255'd0, bmem_read}, 256'd0);
        chk({tag, "_bmem_write"}, {255'd0, bmem_write}, 256'd0);
        chk({tag, "_dfp_resp"}, {255'd0, dfp_resp}, 256'd0);
        chk({tag, "_dfp_dresp"}, {255'd0, dfp_dresp}, 256'd0);
        chk({tag, "_bmem_addr"}, {224'd0, bmem_addr}, 256'd0);
        chk({tag, "_bmem_wdata"}, {192'd0, bmem_wdata}, 256'd0);
        chk({tag, "_dfp_rdata"}, dfp_rdata, 256'd0);
        chk({tag, "_dfp_drdata"}, dfp_drdata, 256'd0);
        chk({tag, "_grant_d"}, {255'd0, grant_d}, 256'd0);
    endtask

    logic [255:0] line_a, line_b, wline;
    int t0, rc0, n;

    initial begin
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_daddr = '0; dfp_dread = 1'b0;
        dfp_dwrite = 1'b0; dfp_dwdata = '0;
        #2;
        check_all_zero("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Icache read, back-to-back beats.
        load_beats({8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}, line_a);
        exp_q.push_back('{is_d: 1'b0, data: line_a, chk_data: 1'b1});
        @(posedge clk); #1;
        dfp_addr = 32'h0000_1000; dfp_read = 1'b1; t0 = cyc; rc0 = rd_cmds;
        @(posedge clk); @(negedge clk);
        chk("rd_cmd_at_t1", {255'd0, bmem_read}, 256'd1);
        chk("rd_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_1000});
        wait_resp(1'b0, "i_read");
        chk("rd_latency", 256'(last_resp_cyc - t0), 256'd6);
        chk("rd_cmd_count", 256'(rd_cmds - rc0), 256'd1);

        // Dcache write with ready toggling.
        for (int k = 0; k < 16; k++) wline[16*k +: 16] = 16'(k);
        wr_log.delete();
        ready_toggle = 1'b1;
        exp_q.push_back('{is_d: 1'b1, data: '0, chk_data: 1'b0});
        @(posedge clk); #1;
        dfp_daddr = 32'h0000_2000; dfp_dwdata = wline; dfp_dwrite = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("wr_valid_at_t1", {255'd0, bmem_write}, 256'd1);
        chk("wr_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_2000});
        wait_resp(1'b1, "d_write");
        ready_toggle = 1'b0;
        chk("wr_beat_count", 256'(wr_log.size()), 256'd4);
        for (int k = 0; k < 4; k++)
            if (k < wr_log.size()) chk("wr_beat", {192'd0, wr_log[k]}, {192'd0, wline[64*k +: 64]});
        chk("wr_resp_delay", 256'(last_resp_cyc - last_wr_cyc), 256'd1);

        // Tie after reset: dcache first, then icache; twice.
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 0) pulse_reset();
            load_beats(64'hD0D0_0000_0000_0001 + 64'(rep), 64'hD0D0_0000_0000_0002,
                       64'hD0D0_0000_0000_0003, 64'hD0D0_0000_0000_0004, line_a);
            load_beats(64'hA1A1_0000_0000_0001 + 64'(rep), 64'hA1A1_0000_0000_0002,
                       64'hA1A1_0000_0000_0003, 64'hA1A1_0000_0000_0004, line_b);
            exp_q.push_back('{is_d: 1'b1, data: line_a, chk_data: 1'b1});
            exp_q.push_back('{is_d: 1'b0, data: line_b, chk_data: 1'b1});
            @(posedge clk); #1;
            dfp_daddr = 32'h0000_3000; dfp_dread = 1'b1;
            dfp_addr  = 32'h0000_1040; dfp_read  = 1'b1;
            @(posedge clk); @(negedge clk);
            chk("tie_grant_d", {255'd0, grant_d}, 256'd1);
            chk("tie_first_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_3000});
            wait_resp(1'b1, "tie_d");
            wait_resp(1'b0, "tie_i");
        end

        // Icache requests while a dcache write is in flight.
        wr_log.delete();
        wline = {4{64'hCAFE_0000_0000_0000}} ^ {64'd3, 64'd2, 64'd1, 64'd0};
        load_beats(64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                   64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, line_a);
        exp_q.push_back('{is_d: 1'b1, data: '0, chk_data: 1'b0});
        exp_q.push_back('{is_d: 1'b0, data: line_a, chk_data: 1'b1});
        @(posedge clk); #1;
        dfp_daddr = 32'h0000_2020; dfp_dwdata = wline; dfp_dwrite = 1'b1;
        rc0 = rd_cmds;
        n = 0;
        while (wr_log.size() < 1 && n < 50) begin @(negedge clk); n++; end
        chk("wr_beat0_timeout", {255'd0, n < 50}, 256'd1);
        dfp_addr = 32'h0000_1000; dfp_read = 1'b1;
        wait_resp(1'b1, "busy_d_write");
        chk("no_interleave_rd", 256'(rd_cmds - rc0), 256'd0);
        chk("busy_wr_beats", 256'(wr_log.size()), 256'd4);
        for (int k = 0; k < 4; k++)
            if (k < wr_log.size()) chk("busy_wr_beat", {192'd0, wr_log[k]}, {192'd0, wline[64*k +: 64]});
        @(negedge clk); @(negedge clk);
        chk("pending_i_cmd", {255'd0, bmem_read}, 256'd1);
        chk("pending_i_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_1000});
        wait_resp(1'b0, "pending_i_read");

        // Reset in the middle of RD_DATA.
        load_beats({8{8'hE1}}, {8{8'hE2}}, {8{8'hE3}}, {8{8'hE4}}, line_a);
        exp_q.push_back('{is_d: 1'b0, data: line_a, chk_data: 1'b1});
        @(posedge clk); #1;
        dfp_addr = 32'h0000_1000; dfp_read = 1'b1; beats_given = 0;
        n = 0;
        while (beats_given < 2 && n < 50) begin @(negedge clk); n++; end
        chk("mid_beats_timeout", {255'd0, n < 50}, 256'd1);
        @(posedge clk); #3;
        chk("pre_rst_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_1000});
        rst = 1'b1;
        beats_left = 0; rd_q.delete(); bmem_rvalid = 1'b0; bmem_rdata = '0;
        void'(exp_q.pop_back());
        dfp_read = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        load_beats({8{8'h55}}, {8{8'h66}}, {8{8'h77}}, {8{8'h88}}, line_a);
        exp_q.push_back('{is_d: 1'b0, data: line_a, chk_data: 1'b1});
        @(posedge clk); #1;
        dfp_addr = 32'h0000_1000; dfp_read = 1'b1; t0 = cyc;
        wait_resp(1'b0, "post_rst_read");
        chk("post_rst_latency", 256'(last_resp_cyc - t0), 256'd6);

        // Stray rvalid in IDLE and during a write.
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wline = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        wr_log.delete();
        exp_q.push_back('{is_d: 1'b1, data: '0, chk_data: 1'b0});
        dfp_daddr = 32'h0000_2040; dfp_dwdata = wline; dfp_dwrite = 1'b1;
        @(posedge clk); @(negedge clk);
        stray = 1'b1;
        wait_resp(1'b1, "stray_d_write");
        chk("stray_wr_beats", 256'(wr_log.size()), 256'd4);
        load_beats({8{8'h99}}, {8{8'hAA}}, {8{8'hBB}}, {8{8'hCC}}, line_a);
        exp_q.push_back('{is_d: 1'b0, data: line_a, chk_data: 1'b1});
        @(posedge clk); #1;
        dfp_addr = 32'h0000_1080; dfp_read = 1'b1; t0 = cyc;
        wait_resp(1'b0, "stray_i_read");
        chk("stray_rd_latency", 256'(last_resp_cyc - t0), 256'd6);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
